// File: rtl/wid_queue_pkg.sv
// wid_queue_pkg: shared defaults and pointer sizing for the AXI write-ID queue
package wid_queue_pkg;
  localparam int DEPTH_DEF     = 4;
  localparam int ID_WIDTH_DEF  = 8;
  localparam int LEN_WIDTH_DEF = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/wid_queue_slot.sv
// wid_queue_slot: one stored AWID (and AWLEN when WID_QUEUE_LEN_CHK_EN is defined)
module wid_queue_slot
  import wid_queue_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF
`ifdef WID_QUEUE_LEN_CHK_EN
  ,parameter int LEN_WIDTH = LEN_WIDTH_DEF
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [ID_WIDTH-1:0] i_id,
`ifdef WID_QUEUE_LEN_CHK_EN
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic [LEN_WIDTH-1:0] o_len,
`endif
  output logic [ID_WIDTH-1:0] o_id
);
  logic [ID_WIDTH-1:0] r_id;
  assign o_id = r_id;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_id <= '0;
    else if (i_we) r_id <= i_id;
`ifdef WID_QUEUE_LEN_CHK_EN
  logic [LEN_WIDTH-1:0] r_len;
  assign o_len = r_len;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_len <= '0;
    else if (i_we) r_len <= i_len;
`endif
endmodule

// File: rtl/wid_queue.sv
// wid_queue: in-order AWID queue supplying WID for each W beat.
// Define WID_QUEUE_LEN_CHK_EN to add AWLEN storage and the sticky wid_len_err check.
module wid_queue
  import wid_queue_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ID_WIDTH  = ID_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 per_clk,
  input  logic                 pad_cpu_rst_b,
  input  logic                 biu_pad_awvalid,
  input  logic [ID_WIDTH-1:0]  biu_pad_awid,
  input  logic [LEN_WIDTH-1:0] biu_pad_awlen,
  output logic                 pad_biu_awready,
  output logic                 x_awvalid,
  input  logic                 x_awready,
  input  logic                 biu_pad_wvalid,
  input  logic                 biu_pad_wlast,
  output logic                 pad_biu_wready,
  output logic                 x_wvalid,
  input  logic                 x_wready,
  output logic [ID_WIDTH-1:0]  wid,
  output logic                 wid_queue_empty,
  output logic                 wid_queue_full,
  output logic                 wid_len_err
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [ID_WIDTH-1:0] w_ids [DEPTH];
  logic w_push, w_id_avail, w_hs, w_pop, w_store, w_deq;
  assign wid_queue_empty = r_count == '0;
  assign wid_queue_full  = r_count == CNT_W'(DEPTH);
  assign x_awvalid       = biu_pad_awvalid & ~wid_queue_full;
  assign pad_biu_awready = x_awready & ~wid_queue_full;
  assign w_push          = biu_pad_awvalid & x_awready & ~wid_queue_full;
  assign w_id_avail      = ~wid_queue_empty | w_push;
  assign x_wvalid        = biu_pad_wvalid & w_id_avail;
  assign pad_biu_wready  = x_wready & w_id_avail;
  assign w_hs            = biu_pad_wvalid & x_wready & w_id_avail;
  assign w_pop           = w_hs & biu_pad_wlast;
  // an ID consumed by a same-cycle bypass never needs to be stored
  assign w_store         = w_push & ~(wid_queue_empty & w_pop);
  assign w_deq           = w_pop & ~wid_queue_empty;
  assign wid             = wid_queue_empty ? biu_pad_awid : w_ids[r_rd_ptr];
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b)
    if (!pad_cpu_rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_store);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq);
      r_count  <= r_count + CNT_W'(w_store) - CNT_W'(w_deq);
    end
`ifdef WID_QUEUE_LEN_CHK_EN
  logic [LEN_WIDTH-1:0] w_lens [DEPTH];
  logic [LEN_WIDTH-1:0] r_beat, w_exp_len;
  logic                 r_len_err, w_len_bad;
  assign w_exp_len   = wid_queue_empty ? biu_pad_awlen : w_lens[r_rd_ptr];
  assign w_len_bad   = biu_pad_wlast ? (r_beat != w_exp_len) : (r_beat == w_exp_len);
  assign wid_len_err = r_len_err;
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b)
    if (!pad_cpu_rst_b) begin
      r_beat    <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_beat    <= w_pop ? '0 : w_hs ? r_beat + 1'b1 : r_beat;
      r_len_err <= r_len_err | (w_hs & w_len_bad);
    end
`else
  logic w_unused_len;
  assign w_unused_len = ^biu_pad_awlen;
  assign wid_len_err  = 1'b0;
`endif
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    wid_queue_slot #(
      .ID_WIDTH (ID_WIDTH)
`ifdef WID_QUEUE_LEN_CHK_EN
      ,.LEN_WIDTH(LEN_WIDTH)
`endif
    ) u_slot (
      .i_clk  (per_clk),
      .i_rst_n(pad_cpu_rst_b),
      .i_we   (w_store && (r_wr_ptr == PTR_W'(i))),
      .i_id   (biu_pad_awid),
`ifdef WID_QUEUE_LEN_CHK_EN
      .i_len  (biu_pad_awlen),
      .o_len  (w_lens[i]),
`endif
      .o_id   (w_ids[i])
    );
  end
endmodule

// File: tb/tb_wid_queue.sv
// tb_wid_queue: directed and random checks of wid_queue against a queue-based model
module tb_wid_queue;
  localparam int DEPTH = 4;
`ifdef WID_QUEUE_LEN_CHK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       awvalid = 0, x_awready = 0, wvalid = 0, wlast = 0, x_wready = 0;
  logic [7:0] awid = 0, awlen = 0;
  logic       awready, x_awvalid, wready, x_wvalid, empty, full, len_err;
  logic [7:0] wid;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  wid_queue #(.DEPTH(DEPTH), .ID_WIDTH(8), .LEN_WIDTH(8)) dut (
    .per_clk(clk), .pad_cpu_rst_b(rst_n),
    .biu_pad_awvalid(awvalid), .biu_pad_awid(awid), .biu_pad_awlen(awlen),
    .pad_biu_awready(awready), .x_awvalid(x_awvalid), .x_awready(x_awready),
    .biu_pad_wvalid(wvalid), .biu_pad_wlast(wlast), .pad_biu_wready(wready),
    .x_wvalid(x_wvalid), .x_wready(x_wready), .wid(wid),
    .wid_queue_empty(empty), .wid_queue_full(full), .wid_len_err(len_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: outstanding AWs as a plain FIFO of (id, len) plus beats since last WLAST
  logic [7:0] q_id [$];
  logic [7:0] q_len [$];
  logic [7:0] m_beats = 0;
  logic       m_err = 0;

  always @(negedge clk) begin
    logic m_empty, m_full, m_push, m_avail, m_hs, m_pop;
    logic [7:0] exp_len;
    if (!rst_n) begin
      q_id.delete(); q_len.delete(); m_beats = 0; m_err = 0;
    end
    m_empty = q_id.size() == 0;
    m_full  = q_id.size() == DEPTH;
    m_push  = awvalid && x_awready && !m_full;
    m_avail = !m_empty || m_push;
    m_hs    = wvalid && x_wready && m_avail;
    m_pop   = m_hs && wlast;
    chk("empty", empty, m_empty);
    chk("full", full, m_full);
    chk("x_awvalid", x_awvalid, awvalid && !m_full);
    chk("awready", awready, x_awready && !m_full);
    chk("x_wvalid", x_wvalid, wvalid && m_avail);
    chk("wready", wready, x_wready && m_avail);
    chk("wid", wid, m_empty ? awid : q_id[0]);
    chk("len_err", len_err, LEN_CHK && m_err);
    if (rst_n) begin
      if (m_hs) begin
        exp_len = m_empty ? awlen : q_len[0];
        if (wlast ? (m_beats != exp_len) : (m_beats == exp_len)) m_err = 1;
        m_beats = m_pop ? 8'd0 : m_beats + 8'd1;
      end
      if (m_push && !(m_empty && m_pop)) begin
        q_id.push_back(awid); q_len.push_back(awlen);
      end
      if (m_pop && !m_empty) begin
        void'(q_id.pop_front()); void'(q_len.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    awvalid = 0; x_awready = 0; wvalid = 0; wlast = 0; x_wready = 0; awid = 0; awlen = 0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); step(); rst_n = 1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_wid", wid, 0);
    chk("rst_x_wvalid", x_wvalid, 0); chk("rst_wready", wready, 0); chk("rst_len_err", len_err, 0);
    step();
    // bypass: AW and single-beat W in the same cycle on an empty queue
    awvalid = 1; x_awready = 1; awid = 8'h15; wvalid = 1; wlast = 1; x_wready = 1; #1;
    chk("byp_wid", wid, 8'h15); chk("byp_x_wvalid", x_wvalid, 1);
    step(); idle(); #1;
    chk("byp_empty_after", empty, 1);
    step();
    // fill to DEPTH, then a fifth AW must be held
    for (int i = 1; i <= 4; i++) begin
      awvalid = 1; x_awready = 1; awid = 8'(i); step();
    end
    awid = 8'h05; #1;
    chk("full_flag", full, 1); chk("full_awready", awready, 0); chk("full_x_awvalid", x_awvalid, 0);
    step();
    for (int b = 1; b <= 4; b++) begin
      wvalid = 1; x_wready = 1; wlast = (b == 4); #1;
      chk("burst_wid", wid, 8'h01);
      if (b == 4) chk("pop_cycle_awready", awready, 0);
      step();
    end
    wvalid = 0; wlast = 0; #1;
    chk("after_pop_wid", wid, 8'h02); chk("after_pop_full", full, 0); chk("fifth_awready", awready, 1);
    step(); awvalid = 0;
    for (int k = 2; k <= 5; k++) begin
      wvalid = 1; wlast = 1; x_wready = 1; #1;
      chk("drain_wid", wid, 8'(k));
      step();
    end
    idle(); #1; chk("drained_empty", empty, 1);
    // W ahead of AW stalls until the AW shows up
    wvalid = 1; wlast = 1; x_wready = 1; #1;
    chk("noid_wready", wready, 0); chk("noid_x_wvalid", x_wvalid, 0);
    step();
    awvalid = 1; x_awready = 1; awid = 8'h7A; #1;
    chk("late_aw_wready", wready, 1); chk("late_aw_wid", wid, 8'h7A);
    step(); idle();
    // one-deep streaming walks both pointers around twice
    awvalid = 1; x_awready = 1; awid = 8'h10; step();
    for (int i = 1; i < 8; i++) begin
      awid = 8'h10 + 8'(i); wvalid = 1; wlast = 1; x_wready = 1; #1;
      chk("wrap_wid", wid, 8'h10 + 8'(i - 1));
      step();
    end
    awvalid = 0; #1; chk("wrap_last_wid", wid, 8'h17); step();
    idle(); #1; chk("wrap_empty", empty, 1);
    // reset in the middle of a burst
    awvalid = 1; x_awready = 1; awid = 8'h20; wvalid = 1; x_wready = 1; wlast = 0; step();
    awvalid = 0; rst_n = 0; #1;
    chk("async_rst_empty", empty, 1); chk("async_rst_len_err", len_err, 0);
    step(); idle(); rst_n = 1; step();
`ifdef WID_QUEUE_LEN_CHK_EN
    awvalid = 1; x_awready = 1; awid = 8'h31; awlen = 8'd3; wvalid = 1; x_wready = 1; step();
    awvalid = 0; wlast = 1; step();
    idle(); #1; chk("short_burst_err", len_err, 1);
    step(); step(); #1; chk("err_sticky", len_err, 1);
    do_reset();
    awvalid = 1; x_awready = 1; awid = 8'h32; awlen = 8'd0; wvalid = 1; wlast = 1; x_wready = 1; step();
    idle(); #1; chk("single_beat_ok", len_err, 0);
    step();
`endif
    for (int c = 0; c < 3000; c++) begin
      awvalid   = $urandom_range(1, 0) == 1;
      x_awready = $urandom_range(9, 0) < 7;
      awid      = 8'($urandom);
      awlen     = 8'($urandom_range(3, 0));
      wvalid    = $urandom_range(9, 0) < 6;
      x_wready  = $urandom_range(9, 0) < 7;
      wlast     = $urandom_range(9, 0) < 4;
      if (c % 997 == 500) rst_n = 0;
      step();
      rst_n = 1;
    end
    idle(); step();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
